// File: rtl/rv_boot_pkg.sv
// Shared definitions for the instruction-memory boot loader and the benches that drive it.
package rv_boot_pkg;

  localparam int XLEN = 32;

  // Canonical RV32I NOP (addi x0, x0, 0), used to pad programs.
  localparam logic [XLEN-1:0] RV_NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    HOLD = 3'd2,
    RUN  = 3'd3,
    ERR  = 3'd4
  } state_t;

endpackage

// File: rtl/boot_hold_timer.sv
// Loadable down-counter that times how long the core stays in reset after a load.
module boot_hold_timer #(
  parameter int HOLD = 4,
  parameter int W    = $clog2(HOLD + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o,
  output logic last_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = W'(HOLD);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);
  // High on the cycle whose closing edge takes the count to zero.
  assign last_o = (cnt_q == W'(1));

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a program into instruction memory from word 0, holds the core in reset
// while loading plus a settle time, then releases it to fetch from PC 0.
module imem_boot_loader
  import rv_boot_pkg::*;
#(
  parameter int DEPTH      = 64,
  parameter int ADDR_W     = $clog2(DEPTH),
  parameter int RESET_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [XLEN-1:0]   ld_data,
  input  logic              ld_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [XLEN-1:0]   imem_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              err_overflow,
  output logic [ADDR_W:0]   word_count,
  output state_t            dbg_state
);

  localparam int CNT_W = ADDR_W + 1;

  state_t              state_q, state_d;
  logic                ld_ready_q, ld_ready_d;
  logic                core_rst_q, core_rst_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    word_count_q, word_count_d;
  logic                imem_we_q, imem_we_d;
  logic [ADDR_W-1:0]   imem_waddr_q, imem_waddr_d;
  logic [XLEN-1:0]     imem_wdata_q, imem_wdata_d;

  logic hs;
  logic hold_zero;
  logic hold_last;
  logic hold_active;

  // Loader handshake: a word transfers on a rising edge where ld_valid and ld_ready
  // are both high; ld_data/ld_last are only meaningful in that cycle, and ld_ready
  // is a registered output so the loader may look at it without a combinational path.
  assign hs          = ld_valid & ld_ready_q;
  assign hold_active = (state_q == HOLD);

  boot_hold_timer #(
    .HOLD (RESET_HOLD)
  ) u_hold_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (hs & ld_last),
    .dec_i  (hold_active),
    .zero_o (hold_zero),
    .last_o (hold_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: begin
        if (hs) begin
          if (ld_last) begin
            state_d = HOLD;
          end else if (word_count_q == CNT_W'(DEPTH - 1)) begin
            state_d = ERR;
          end
        end
      end
      HOLD: if (hold_last || hold_zero) state_d = RUN;
      RUN:  if (start) state_d = LOAD;
      ERR:  if (start) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  // Every output is registered, so each one is derived from the state being entered.
  always_comb begin
    ld_ready_d   = (state_d == LOAD);
    core_rst_d   = (state_d != RUN);
    done_d       = (state_d == RUN);

    err_d = err_q;
    if ((state_q == LOAD) && (state_d == ERR)) begin
      err_d = 1'b1;
    end else if ((state_q == ERR) && (state_d == LOAD)) begin
      err_d = 1'b0;
    end

    word_count_d = word_count_q;
    if (hs) begin
      word_count_d = word_count_q + 1'b1;
    end else if ((state_q != LOAD) && (state_d == LOAD)) begin
      word_count_d = '0;
    end

    // The write trails its accept by one edge; address is the pre-increment count.
    imem_we_d    = hs;
    imem_waddr_d = hs ? word_count_q[ADDR_W-1:0] : imem_waddr_q;
    imem_wdata_d = hs ? ld_data : imem_wdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_ready_q   <= 1'b0;
      core_rst_q   <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      word_count_q <= '0;
      imem_we_q    <= 1'b0;
      imem_waddr_q <= '0;
      imem_wdata_q <= '0;
    end else begin
      ld_ready_q   <= ld_ready_d;
      core_rst_q   <= core_rst_d;
      done_q       <= done_d;
      err_q        <= err_d;
      word_count_q <= word_count_d;
      imem_we_q    <= imem_we_d;
      imem_waddr_q <= imem_waddr_d;
      imem_wdata_q <= imem_wdata_d;
    end
  end

  assign ld_ready     = ld_ready_q;
  assign core_rst     = core_rst_q;
  assign done         = done_q;
  assign err_overflow = err_q;
  assign word_count   = word_count_q;
  assign imem_we      = imem_we_q;
  assign imem_waddr   = imem_waddr_q;
  assign imem_wdata   = imem_wdata_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed scenarios plus randomized loads
// compared every cycle against a behavioural model of the loader.
module tb_imem_boot_loader;
  import rv_boot_pkg::*;

  localparam int DEPTH      = 4;
  localparam int ADDR_W     = 2;
  localparam int RESET_HOLD = 4;
  localparam int WR_W       = ADDR_W + XLEN;

  // ---------------- clock / reset / DUT ----------------
  logic              clk      = 1'b0;
  logic              rst      = 1'b0;
  logic              start    = 1'b0;
  logic              ld_valid = 1'b0;
  logic              ld_last  = 1'b0;
  logic [XLEN-1:0]   ld_data  = '0;
  logic              ld_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [XLEN-1:0]   imem_wdata;
  logic              core_rst;
  logic              done;
  logic              err_overflow;
  logic [ADDR_W:0]   word_count;
  state_t            dbg_state;

  always #5 clk = ~clk;

  imem_boot_loader #(
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W),
    .RESET_HOLD (RESET_HOLD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_data      (ld_data),
    .ld_last      (ld_last),
    .imem_we      (imem_we),
    .imem_waddr   (imem_waddr),
    .imem_wdata   (imem_wdata),
    .core_rst     (core_rst),
    .done         (done),
    .err_overflow (err_overflow),
    .word_count   (word_count),
    .dbg_state    (dbg_state)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking helpers ----------------
  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Loader described by what it is doing: accepting words, counting down a settle
  // time, running, or sitting in overflow; writes go to an expected queue.
  logic [WR_W-1:0] exp_q[$];
  bit m_loading  = 1'b0;
  bit m_running  = 1'b0;
  bit m_err      = 1'b0;
  bit m_we       = 1'b0;
  int m_holdleft = 0;
  int m_count    = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_loading  <= 1'b0;
      m_running  <= 1'b0;
      m_err      <= 1'b0;
      m_we       <= 1'b0;
      m_holdleft <= 0;
      m_count    <= 0;
      exp_q.delete();
    end else if (m_loading && ld_valid) begin
      m_we    <= 1'b1;
      exp_q.push_back({ADDR_W'(m_count), ld_data});
      m_count <= m_count + 1;
      if (ld_last) begin
        m_loading  <= 1'b0;
        m_holdleft <= RESET_HOLD;
      end else if (m_count + 1 == DEPTH) begin
        m_loading <= 1'b0;
        m_err     <= 1'b1;
      end
    end else begin
      m_we <= 1'b0;
      if (!m_loading && m_holdleft > 0) begin
        m_holdleft <= m_holdleft - 1;
        if (m_holdleft == 1) m_running <= 1'b1;
      end else if (!m_loading && start) begin
        m_loading <= 1'b1;
        m_running <= 1'b0;
        m_err     <= 1'b0;
        m_count   <= 0;
      end
    end
  end

  // ---------------- scoreboard: every cycle ----------------
  always @(negedge clk) begin
    if (check_en) begin
      chk("ld_ready", ld_ready, m_loading);
      chk("core_rst", core_rst, !m_running);
      chk("done", done, m_running);
      chk("err_overflow", err_overflow, m_err);
      chk("word_count", word_count, m_count);
      chk("imem_we", imem_we, m_we);
      if (m_we) begin
        chk("wr_queue_depth", exp_q.size(), 1);
        if (exp_q.size() > 0) chk("imem_write", {imem_waddr, imem_wdata}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [XLEN-1:0] prog[8];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_prog(input int n, input bit use_last, input int gap_pct,
                           input int budget, input bit rand_start, output int accepted);
    int cycles;
    cycles   = 0;
    accepted = 0;
    while (accepted < n && cycles < budget) begin
      @(negedge clk);
      cycles++;
      ld_valid = ($urandom_range(99) >= gap_pct);
      ld_data  = ld_valid ? prog[accepted] : $urandom();
      ld_last  = use_last && (accepted == n - 1);
      start    = rand_start && ($urandom_range(15) == 0);
      if (ld_valid && ld_ready) accepted++;
    end
    @(negedge clk);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    start    = 1'b0;
    ld_data  = $urandom();
  endtask

  task automatic wait_run(input int budget, output int edges);
    edges = 0;
    while (!done && edges < budget) begin
      @(negedge clk);
      edges++;
    end
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int acc;
    int edges;
    int k;
    bit pat[5];

    #1 rst = 1'b1;
    #1 check_en = 1'b1;
    @(negedge clk);
    chk("rst_core_rst", core_rst, 1'b1);
    chk("rst_ld_ready", ld_ready, 1'b0);
    chk("rst_imem_we", imem_we, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err_overflow, 1'b0);
    chk("rst_state", dbg_state, IDLE);
    ld_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tick(3);
    chk("idle_ignores_valid", word_count, 0);
    ld_valid = 1'b0;

    // Basic three-word load, valid held high.
    prog[0] = 32'h0050_0093;
    prog[1] = 32'h0030_0113;
    prog[2] = 32'h0020_81b3;
    pulse_start();
    send_prog(3, 1'b1, 0, 20, 1'b0, acc);
    chk("basic_accepted", acc, 3);
    chk("basic_last_waddr", imem_waddr, 2);
    chk("basic_last_wdata", imem_wdata, 32'h0020_81b3);
    chk("basic_word_count", word_count, 3);
    wait_run(20, edges);
    chk("basic_release_edges", edges, RESET_HOLD);

    // Reload from RUN, then backpressure pattern 1,0,0,1,1.
    pulse_start();
    chk("reload_core_rst", core_rst, 1'b1);
    chk("reload_done", done, 1'b0);
    chk("reload_word_count", word_count, 0);
    chk("reload_ld_ready", ld_ready, 1'b1);
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) prog[i] = $urandom();
    k = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ld_valid = pat[i];
      ld_data  = pat[i] ? prog[k] : $urandom();
      ld_last  = (i == 4);
      if (ld_valid && ld_ready) k++;
    end
    @(negedge clk);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    chk("gap_word_count", word_count, 3);
    wait_run(20, edges);
    chk("gap_done", done, 1'b1);

    // Overflow: five words, no last.
    for (int i = 0; i < 8; i++) prog[i] = $urandom();
    pulse_start();
    send_prog(5, 1'b0, 0, 12, 1'b0, acc);
    chk("ovf_accepted", acc, DEPTH);
    chk("ovf_err", err_overflow, 1'b1);
    chk("ovf_core_rst", core_rst, 1'b1);
    chk("ovf_word_count", word_count, DEPTH);
    chk("ovf_state", dbg_state, ERR);
    pulse_start();
    chk("ovf_clear_err", err_overflow, 1'b0);
    chk("ovf_clear_count", word_count, 0);

    // Exact fit: DEPTH words with last on the final one.
    send_prog(DEPTH, 1'b1, 30, 60, 1'b0, acc);
    chk("fit_accepted", acc, DEPTH);
    wait_run(20, edges);
    chk("fit_done", done, 1'b1);
    chk("fit_err", err_overflow, 1'b0);
    chk("fit_word_count", word_count, DEPTH);

    // Randomized loads with gaps, stray starts and occasional missing last.
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 8; i++) prog[i] = ($urandom_range(3) == 0) ? RV_NOP : $urandom();
      pulse_start();
      send_prog($urandom_range(1, 6), ($urandom_range(4) != 0), $urandom_range(0, 50),
                60, 1'b1, acc);
      tick($urandom_range(2, 8));
    end

    // Asynchronous reset between edges with a write pending.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pulse_start();
    send_prog(2, 1'b0, 0, 10, 1'b0, acc);
    #2 rst = 1'b1;
    #1;
    chk("arst_imem_we", imem_we, 1'b0);
    chk("arst_core_rst", core_rst, 1'b1);
    chk("arst_ld_ready", ld_ready, 1'b0);
    chk("arst_word_count", word_count, 0);
    @(negedge clk);
    rst = 1'b0;
    ld_valid = 1'b1;
    tick(4);
    chk("arst_idle_state", dbg_state, IDLE);
    ld_valid = 1'b0;
    pulse_start();
    send_prog(2, 1'b1, 0, 10, 1'b0, acc);
    wait_run(20, edges);
    chk("arst_reload_done", done, 1'b1);

    tick(2);
    chk("exp_q_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Hardware counterpart to the bench stimulus that drives clk/rst and watches PC/instruction on the single-cycle RV32I core.
- Accepts a program as a stream of 32-bit instruction words over a valid/ready handshake and writes them into instruction memory from word address 0.
- Holds the core in reset while loading, then for a fixed settle time, then releases it so the core fetches from PC 0.
- Sits between the external loader interface (bench or UART front end) and the instruction memory write port plus the core reset input.

Parameters:
- XLEN, 32, instruction word width.
- DEPTH, 64, instruction memory depth in words. Power of two, at least 2.
- ADDR_W, 6, word-address width; equals log2(DEPTH).
- RESET_HOLD, 4, cycles core_rst stays high after the last word is accepted. Minimum 1.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle pulse that begins a program load.
- ld_valid  in  1  loader word valid.
- ld_ready  out  1  block can accept a word.
- ld_data  in  XLEN  instruction word.
- ld_last  in  1  marks the final word; qualified by ld_valid & ld_ready.
- imem_we  out  1  instruction memory write enable.
- imem_waddr  out  ADDR_W  word index; byte PC = index*4.
- imem_wdata  out  XLEN  write data.
- core_rst  out  1  reset to the core, active-high.
- done  out  1  core is running a loaded program.
- err_overflow  out  1  sticky: program exceeded DEPTH.
- word_count  out  ADDR_W+1  words accepted in the current load.

Behaviour:
- Reset (asynchronous): state IDLE, core_rst=1, ld_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, done=0, err_overflow=0, word_count=0, hold counter 0.
- All outputs are registered.
- States: IDLE, LOAD, HOLD, RUN, ERR.
- IDLE:
  - core_rst=1, ld_ready=0.
  - On start → LOAD at the next edge; word_count cleared to 0.
  - ld_valid is ignored.
- LOAD:
  - ld_ready=1. A handshake is ld_valid & ld_ready at an edge.
  - At handshake edge N: word_count increments.
  - At edge N+1: imem_we=1, imem_waddr=word_count before the increment, imem_wdata=ld_data. The write is one cycle after the accept.
  - Back-to-back handshakes produce back-to-back writes.
  - imem_we is 0 in any cycle with no pending write.
  - Handshake with ld_last=1 → HOLD, ld_ready=0 from that edge, hold counter loaded with RESET_HOLD.
  - Handshake at word_count==DEPTH-1 with ld_last=0: the word is still written, then → ERR with err_overflow=1.
  - start while in LOAD is ignored.
- HOLD:
  - core_rst=1. The hold counter decrements each edge.
  - The edge where the counter reaches 0 moves the state to RUN. That edge is RESET_HOLD edges after the ld_last handshake.
  - The final imem write always lands before core_rst falls.
- RUN:
  - core_rst=0, done=1.
  - start → next edge: LOAD, core_rst=1, done=0, word_count=0 (reload).
- ERR:
  - core_rst=1, ld_ready=0, err_overflow=1 (sticky).
  - start → LOAD with err_overflow cleared. Only rst or start leave ERR.
- Simultaneous events:
  - start and a handshake in the same IDLE cycle: the handshake is impossible because ld_ready=0.
  - ld_last on the DEPTH-th word: a normal completion (HOLD), not an error.
- Reset mid-load: all outputs go to reset values immediately. A write pending for the next edge is dropped. Memory contents already written are not cleared.
- word_count never exceeds DEPTH. It holds its final value in HOLD, RUN and ERR.

Decomposition:
- Shared package rv_boot_pkg holds:
  - the state enum (IDLE/LOAD/HOLD/RUN/ERR);
  - XLEN;
  - the RV32I NOP encoding 32'h00000013, used by benches to pad programs.
- One natural sub-module, boot_hold_timer: a loadable down-counter with a zero flag, width $clog2(RESET_HOLD+1). Everything else stays in one FSM.

Test Plan:
- Basic load: rst high for 1 cycle, start, then stream 32'h00500093, 32'h00300113, 32'h002081b3 (last on the third word) with ld_valid held high.
  - Writes appear at addresses 0, 1, 2, each one cycle after its accept.
  - word_count=3.
  - core_rst falls and done rises exactly 4 edges after the third accept.
- Backpressure and gaps: ld_valid toggles 1,0,0,1,1 → writes only on the cycle after each handshake, no duplicates, addresses contiguous.
- Overflow (DEPTH=4): send 5 words with no ld_last.
  - Words 0-3 are written; the 5th is never accepted (ld_ready=0).
  - err_overflow=1, core_rst stays 1.
  - start afterwards clears err_overflow and reloads from address 0.
- Exact fit (DEPTH=4): 4 words with ld_last on the 4th → HOLD then RUN, err_overflow=0.
- Reload from RUN: start → core_rst=1 and done=0 at the next edge, word_count=0, and the new program writes again from address 0.
- Async reset mid-load: assert rst between clock edges after 2 accepts.
  - core_rst=1, ld_ready=0, imem_we=0 immediately, with no write for the pending word.
  - After reset releases, state is IDLE and start is required to load again.
